// File: rtl/race_sequencer.sv
// race_sequencer: game tick prescaler, motion/drop strobes, IDLE/PLAY/CRASH/OVER FSM, lives and score.
module race_sequencer #(
  parameter int TICK_DIV    = 833333,
  parameter int DROP_TICKS  = 90,
  parameter int CRASH_TICKS = 120,
  parameter int LIVES       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        colision,
  input  logic        fast,
  output logic        upsig,
  output logic        upsig_fast,
  output logic        drop,
  output logic        round_clear,
  output logic [1:0]  lives,
  output logic [1:0]  state,
  output logic [15:0] score
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DROP_TICKS + 1);
  localparam int FW = $clog2(CRASH_TICKS + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, CRASH = 2'b10, OVER = 2'b11} st_t;
  st_t st, st_n;
  logic [TW-1:0] tick_cnt;
  logic [DW-1:0] drop_cnt;
  logic [FW-1:0] freeze_cnt;
  logic [15:0] score_q;
  logic start_q, tick, half, start_edge, new_game, crash_done;
  assign state = st;
  assign score = score_q;
  // Strobes are gated by reset so nothing fires while the registers are being cleared.
  always_comb begin
    tick = tick_cnt == TW'(TICK_DIV - 1);
    half = tick_cnt == TW'(TICK_DIV / 2 - 1);
    start_edge = start & ~start_q;
    upsig = ~reset & tick & (st == PLAY);
    upsig_fast = ~reset & (st == PLAY) & (tick | (fast & half));
    drop = upsig & (drop_cnt == DW'(DROP_TICKS - 1));
    new_game = ~reset & start_edge & ((st == IDLE) | (st == OVER));
    crash_done = (st == CRASH) & tick & (freeze_cnt == '0);
    round_clear = new_game | (~reset & crash_done & (lives != 2'd0));
    st_n = st;
    if (new_game) st_n = PLAY;
    if (st == PLAY && colision) st_n = CRASH;
    if (crash_done) st_n = (lives == 2'd0) ? OVER : PLAY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      tick_cnt <= '0;
      drop_cnt <= '0;
      freeze_cnt <= '0;
      lives <= 2'd0;
      score_q <= 16'd0;
      start_q <= 1'b1;
    end else begin
      st <= st_n;
      start_q <= start;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (round_clear) drop_cnt <= '0;
      else if (upsig) drop_cnt <= drop ? '0 : drop_cnt + 1'b1;
      if (new_game) begin
        lives <= 2'(LIVES);
        score_q <= 16'd0;
      end else begin
        if (upsig_fast && score_q != 16'hFFFF) score_q <= score_q + 16'd1;
        if (st == PLAY && colision) begin
          lives <= lives - 2'd1;
          freeze_cnt <= FW'(CRASH_TICKS - 1);
        end
        if (st == CRASH && tick && freeze_cnt != '0) freeze_cnt <= freeze_cnt - 1'b1;
      end
    end
  end
endmodule
